// File: rtl/cpu_mem_arbiter.sv
// Shares one SRAM-like port between instruction fetch and data access.
// Issues one access at a time, round-robin on contention, and returns the read data to its owner.
module cpu_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_req,
  input  logic [AW-1:0]   inst_addr,
  output logic [DW-1:0]   inst_rdata,
  output logic            inst_done,
  input  logic            data_en,
  input  logic [DW/8-1:0] data_wen,
  input  logic [AW-1:0]   data_addr,
  input  logic [DW-1:0]   data_wdata,
  output logic [DW-1:0]   data_rdata,
  output logic            data_done,
  output logic            stall,
  output logic            mem_req,
  output logic            mem_wr,
  output logic [DW/8-1:0] mem_wen,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2
  } stateT;

  stateT state;
  stateT nextState;
  logic  lastGrantData;
  logic  dataElig;
  logic  instElig;
  logic  grantData;
  logic  grantInst;

  // A requester in its done cycle still holds its request; it must not be re-granted then.
  always_comb begin
    nextState = state;
    grantData = 1'b0;
    grantInst = 1'b0;
    dataElig  = data_en & ~data_done;
    instElig  = inst_req & ~inst_done;
    unique case (state)
      IDLE: begin
        if (dataElig && (!instElig || !lastGrantData)) begin
          grantData = 1'b1;
          nextState = DATA;
        end else if (instElig) begin
          grantInst = 1'b1;
          nextState = INST;
        end
      end
      DATA, INST: begin
        if (mem_ack) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lastGrantData <= 1'b0;
      mem_req       <= 1'b0;
      mem_wr        <= 1'b0;
      mem_wen       <= '0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      inst_rdata    <= '0;
      data_rdata    <= '0;
      inst_done     <= 1'b0;
      data_done     <= 1'b0;
    end else begin
      state     <= nextState;
      inst_done <= 1'b0;
      data_done <= 1'b0;
      // Grant: latch the winner's request so later input changes cannot disturb the access.
      if (grantData) begin
        lastGrantData <= 1'b1;
        mem_req       <= 1'b1;
        mem_wr        <= |data_wen;
        mem_wen       <= data_wen;
        mem_addr      <= data_addr;
        mem_wdata     <= data_wdata;
      end else if (grantInst) begin
        lastGrantData <= 1'b0;
        mem_req       <= 1'b1;
        mem_wr        <= 1'b0;
        mem_wen       <= '0;
        mem_addr      <= inst_addr;
        mem_wdata     <= '0;
      end
      // Completion: acks seen while idle carry no owner and are dropped.
      if (state != IDLE && mem_ack) begin
        mem_req <= 1'b0;
        if (state == DATA) begin
          data_done <= 1'b1;
          if (!mem_wr) begin
            data_rdata <= mem_rdata;
          end
        end else begin
          inst_done  <= 1'b1;
          inst_rdata <= mem_rdata;
        end
      end
    end
  end

  assign stall = (inst_req & ~inst_done) | (data_en & ~data_done);

  doneExclusive: assert property (@(posedge clk) disable iff (rst) !(inst_done && data_done));
  reqMatchesBusy: assert property (@(posedge clk) disable iff (rst) mem_req == (state != IDLE));

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: vector table, directed corner sequences and a randomized phase
// checked against a transaction-level memory model.
module tb_cpu_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst_rdata;
  logic          inst_done;
  logic          data_en;
  logic [3:0]    data_wen;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic [DW-1:0] data_rdata;
  logic          data_done;
  logic          stall;
  logic          mem_req;
  logic          mem_wr;
  logic [3:0]    mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  always #5 clk = ~clk;

  cpu_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_done(inst_done),
    .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_done(data_done), .stall(stall),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int nChecks = 0;
  int nFail = 0;

  typedef struct {
    bit         isData;
    logic [3:0] wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] memRdata;
    int         lat;
    logic [31:0] expRdata;
    logic       expWr;
    logic [3:0] expWen;
    logic [31:0] expWdata;
  } vecT;
  vecT vecs[6];

  // Memory responder state (random phase) and reference model state
  bit          autoMem = 1'b0;
  bit          busy = 1'b0;
  int          waitCnt = 0;
  bit          ownerData = 1'b0;
  logic        capWr;
  logic [3:0]  capWen;
  logic [31:0] capAddr, capWdata;
  bit          expI = 1'b0, expD = 1'b0;
  logic [31:0] memArr [logic [31:0]];
  logic [31:0] refMem [logic [31:0]];
  bit          iAct = 1'b0, dAct = 1'b0;
  int          iAge = 0, dAge = 0;
  logic [31:0] iAddr, iExp, dAddr, dWdata, dExp, lastLoad;
  logic [3:0]  dWen;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] initVal(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] wen);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (wen[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Memory side: acks after a random latency and stores writes.
  task automatic memStep();
    logic [31:0] old;
    expI = 1'b0;
    expD = 1'b0;
    if (mem_ack) begin
      mem_ack = 1'b0;
      busy = 1'b0;
      if (ownerData) expD = 1'b1; else expI = 1'b1;
      check("rnd_req_drop", mem_req, 1'b0);
    end else if (mem_req) begin
      if (!busy) begin
        busy = 1'b1;
        waitCnt = $urandom_range(0, 4);
        {capWr, capWen, capAddr, capWdata} = {mem_wr, mem_wen, mem_addr, mem_wdata};
        ownerData = (mem_addr[31:28] != 4'hB);
        if (ownerData) begin
          check("rnd_data_owner", dAct, 1'b1);
          check("rnd_data_req", {mem_wr, mem_wen, mem_addr, mem_wdata},
                {|dWen, dWen, dAddr, dWdata});
        end else begin
          check("rnd_inst_owner", iAct, 1'b1);
          check("rnd_inst_req", {mem_wr, mem_wen, mem_addr, mem_wdata}, {1'b0, 4'h0, iAddr, 32'h0});
        end
      end else begin
        check("rnd_stable", {mem_wr, mem_wen, mem_addr, mem_wdata},
              {capWr, capWen, capAddr, capWdata});
      end
      if (waitCnt == 0) begin
        mem_ack = 1'b1;
        old = memArr.exists(mem_addr) ? memArr[mem_addr] : initVal(mem_addr);
        if (mem_wr) begin
          memArr[mem_addr] = merge(old, mem_wdata, mem_wen);
          mem_rdata = $urandom;
        end else begin
          mem_rdata = old;
        end
      end else begin
        waitCnt--;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (autoMem) memStep();
  endtask

  task automatic ackWith(input logic [31:0] d);
    mem_ack = 1'b1;
    mem_rdata = d;
    tick();
    mem_ack = 1'b0;
    mem_rdata = $urandom;
  endtask

  task automatic idleInputs();
    inst_req = 0; inst_addr = '0; data_en = 0; data_wen = '0; data_addr = '0; data_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic checkResetState(input string nm);
    check({nm, "_mem"}, {mem_req, mem_wr, mem_wen, mem_addr, mem_wdata}, '0);
    check({nm, "_rdata"}, {inst_rdata, data_rdata}, '0);
    check({nm, "_done"}, {inst_done, data_done}, '0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    idleInputs();
    tick();
    rst = 1'b0;
    #1;
    checkResetState("reset");
    check("reset_stall", stall, 1'b0);
  endtask

  task automatic runVec(input vecT v, input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    if (v.isData) begin
      data_en = 1; data_wen = v.wen; data_addr = v.addr; data_wdata = v.wdata;
    end else begin
      inst_req = 1; inst_addr = v.addr; data_wdata = v.wdata;
    end
    #1;
    check({nm, "_stall_wait"}, stall, 1'b1);
    tick();
    check({nm, "_issue"}, {mem_req, mem_wr, mem_wen, mem_addr, mem_wdata},
          {1'b1, v.expWr, v.expWen, v.addr, v.expWdata});
    for (int k = 0; k < v.lat; k++) begin
      tick();
      check({nm, "_hold"}, {mem_req, stall, inst_done, data_done, mem_addr}, {4'b1100, v.addr});
    end
    ackWith(v.memRdata);
    check({nm, "_done"}, {inst_done, data_done}, v.isData ? 2'b01 : 2'b10);
    check({nm, "_rdata"}, v.isData ? data_rdata : inst_rdata, v.expRdata);
    check({nm, "_after"}, {mem_req, stall}, 2'b00);
    inst_req = 0; data_en = 0;
    tick();
    check({nm, "_pulse"}, {inst_done, data_done}, 2'b00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit abort;
    abort = 1'b0;
    rst = 1'b0;
    idleInputs();
    vecs[0] = '{1'b0, 4'h0, 32'hBFC0_0000, 32'h0000_0000, 32'h3C08_0001, 0, 32'h3C08_0001, 1'b0, 4'h0, 32'h0};
    vecs[1] = '{1'b1, 4'h3, 32'h8000_0010, 32'h1234_5678, 32'hDEAD_BEEF, 0, 32'h0000_0000, 1'b1, 4'h3, 32'h1234_5678};
    vecs[2] = '{1'b1, 4'h0, 32'h8000_0020, 32'h0BAD_F00D, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 1'b0, 4'h0, 32'h0BAD_F00D};
    vecs[3] = '{1'b1, 4'hF, 32'h8000_0024, 32'hA5A5_A5A5, 32'h1111_1111, 2, 32'hCAFE_F00D, 1'b1, 4'hF, 32'hA5A5_A5A5};
    vecs[4] = '{1'b0, 4'h0, 32'hBFC0_0004, 32'h9999_9999, 32'h2402_0005, 3, 32'h2402_0005, 1'b0, 4'h0, 32'h0};
    vecs[5] = '{1'b1, 4'h8, 32'h8000_0028, 32'h7700_0000, 32'h2222_2222, 0, 32'hCAFE_F00D, 1'b1, 4'h8, 32'h7700_0000};
    repeat (2) @(posedge clk);
    doReset();
    for (int i = 0; i < 6; i++) runVec(vecs[i], i);

    // Contention: data wins first after reset, then alternation
    doReset();
    inst_req = 1; inst_addr = 32'hBFC0_0100;
    data_en = 1; data_wen = 4'h0; data_addr = 32'h8000_0040;
    tick();
    check("ct1_data_first", {mem_req, mem_wr, mem_addr}, {2'b10, 32'h8000_0040});
    ackWith(32'h1357_2468);
    check("ct1_data_done", {data_done, inst_done, stall, mem_req}, 4'b1010);
    check("ct1_data_rdata", data_rdata, 32'h1357_2468);
    data_en = 0;
    tick();
    check("ct1_inst_next", {mem_req, mem_wr, mem_addr}, {2'b10, 32'hBFC0_0100});
    ackWith(32'h0F0F_0F0F);
    check("ct1_inst_done", {inst_done, inst_rdata}, {1'b1, 32'h0F0F_0F0F});
    inst_req = 0;
    tick();
    inst_req = 1; inst_addr = 32'hBFC0_0200;
    data_en = 1; data_addr = 32'h8000_0044;
    tick();
    check("ct2_data_first", mem_addr, 32'h8000_0044);
    ackWith(32'h2468_1357);
    data_en = 0;
    tick();
    check("ct2_inst_next", {mem_req, mem_addr}, {1'b1, 32'hBFC0_0200});
    ackWith(32'h3333_4444);
    inst_req = 0;
    tick();
    data_en = 1; data_addr = 32'h8000_0048;
    tick();
    ackWith(32'h5555_6666);
    data_en = 0;
    tick();
    inst_req = 1; inst_addr = 32'hBFC0_0300;
    data_en = 1; data_addr = 32'h8000_004C;
    tick();
    check("ct3_inst_first", {mem_req, mem_addr}, {1'b1, 32'hBFC0_0300});
    ackWith(32'h7777_8888);
    inst_req = 0;
    tick();
    check("ct3_data_next", {mem_req, mem_addr}, {1'b1, 32'h8000_004C});
    ackWith(32'h9999_AAAA);
    check("ct3_data_done", {data_done, data_rdata}, {1'b1, 32'h9999_AAAA});
    data_en = 0;
    tick();

    // Long latency with the fetch address changing underneath
    inst_req = 1; inst_addr = 32'hBFC0_0400;
    tick();
    for (int k = 0; k < 5; k++) begin
      inst_addr = $urandom;
      tick();
      check("lat_hold", {mem_req, stall, inst_done, mem_wr, mem_addr}, {4'b1100, 32'hBFC0_0400});
    end
    ackWith(32'hB0B0_C0C0);
    check("lat_done", {inst_done, inst_rdata, stall}, {1'b1, 32'hB0B0_C0C0, 1'b0});
    inst_req = 0;
    tick();

    // Reset two cycles into a read; acks during and after reset are ignored
    data_en = 1; data_wen = 4'h0; data_addr = 32'h8000_0050;
    tick();
    tick();
    rst = 1; mem_ack = 1; mem_rdata = 32'hEEEE_EEEE; data_en = 0;
    tick();
    rst = 0;
    checkResetState("rmid");
    tick();
    mem_ack = 0;
    check("rmid_late_ack", {data_done, inst_done, mem_req, data_rdata}, '0);

    // Stray ack while idle
    mem_ack = 1; mem_rdata = 32'hFFFF_0000;
    tick();
    mem_ack = 0;
    check("stray_ack", {inst_done, data_done, mem_req, inst_rdata}, '0);
    inst_req = 1; inst_addr = 32'hBFC0_0500;
    tick();
    check("stray_idle", {mem_req, mem_addr}, {1'b1, 32'hBFC0_0500});
    ackWith(32'h0102_0304);
    check("stray_fetch", {inst_done, inst_rdata}, {1'b1, 32'h0102_0304});
    inst_req = 0;
    tick();

    // Randomized traffic against the memory model
    doReset();
    lastLoad = '0;
    autoMem = 1'b1;
    for (int c = 0; c < 3000 && !abort; c++) begin
      tick();
      check("rnd_inst_done", inst_done, expI);
      check("rnd_data_done", data_done, expD);
      if (expI) begin
        check("rnd_inst_rdata", inst_rdata, iExp);
        iAct = 1'b0;
      end
      if (expD) begin
        check("rnd_data_rdata", data_rdata, dExp);
        dAct = 1'b0;
      end
      if (iAct) iAge++;
      if (dAct) dAge++;
      if (iAge > 64 || dAge > 64) begin
        check("rnd_timeout", {iAge > 64, dAge > 64}, 2'b00);
        abort = 1'b1;
      end
      if (!iAct) begin
        if ($urandom_range(0, 2) == 0) begin
          iAct = 1; iAge = 0;
          iAddr = 32'hBFC0_0000 + ($urandom_range(0, 63) << 2);
          iExp = initVal(iAddr);
          inst_req = 1; inst_addr = iAddr;
        end else begin
          inst_req = 0;
        end
      end
      if (!dAct) begin
        if ($urandom_range(0, 2) == 0) begin
          dAct = 1; dAge = 0;
          dAddr = 32'h8000_0000 + ($urandom_range(0, 15) << 2);
          dWen = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
          dWdata = $urandom;
          if (dWen == 4'h0) begin
            dExp = refMem.exists(dAddr) ? refMem[dAddr] : initVal(dAddr);
            lastLoad = dExp;
          end else begin
            refMem[dAddr] = merge(refMem.exists(dAddr) ? refMem[dAddr] : initVal(dAddr), dWdata, dWen);
            dExp = lastLoad;
          end
          data_en = 1; data_wen = dWen; data_addr = dAddr; data_wdata = dWdata;
        end else begin
          data_en = 0;
        end
      end
      #1;
      check("rnd_stall", stall, (inst_req && !expI) || (data_en && !expD));
    end
    autoMem = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
